// File: rtl/seq_math_unit_pkg.sv
// Shared types for seq_math_unit: operation codes, FSM states and counter sizing.
package seq_math_unit_pkg;

  typedef enum logic [1:0] {
    MATH_DIV     = 2'd0,
    MATH_CEILDIV = 2'd1,
    MATH_CLOG2   = 2'd2,
    MATH_MAX     = 2'd3
  } math_op_e;

  typedef enum logic [1:0] {
    SMU_IDLE = 2'd0,
    SMU_BUSY = 2'd1,
    SMU_DONE = 2'd2
  } smu_state_e;

  // Iteration counter must hold W-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_div_core.sv
// Restoring divider, one quotient bit per cycle MSB first; start loads operands and runs W steps.
module seq_div_core import seq_math_unit_pkg::*; #(
  parameter int unsigned W    = 32,
  parameter int unsigned CntW = cnt_width(W)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [W-1:0]    dividend_i,
  input  logic [W-1:0]    divisor_i,
  output logic            done_o,
  output logic [CntW-1:0] cnt_o,
  output logic [W-1:0]    q_o,
  output logic [W-1:0]    r_o
);

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    rem_q;
  logic [W:0]      rem_shift;
  logic [W:0]      rem_sub;
  logic            fits;
  logic [W-1:0]    rem_d;

  // Divisor of zero always "fits", which naturally yields q=all ones, r=dividend.
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    rem_sub   = rem_shift - {1'b0, divisor_i};
    fits      = (rem_shift >= {1'b0, divisor_i});
    rem_d     = fits ? rem_sub[W-1:0] : rem_shift[W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CntW'(W - 1);
      quo_q  <= dividend_i;
      rem_q  <= '0;
    end else if (busy_q) begin
      quo_q <= {quo_q[W-2:0], fits};
      rem_q <= rem_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign done_o = busy_q && (cnt_q == '0);
  assign cnt_o  = cnt_q;
  assign q_o    = quo_q;
  assign r_o    = rem_q;

endmodule

// File: rtl/seq_math_unit.sv
// Multi-cycle DIV/CEILDIV/CLOG2/MAX engine with fixed W+1 cycle latency.
// Optional divide-by-zero flag output enabled by SEQ_MATH_UNIT_DIV0_FLAG_EN.
module seq_math_unit import seq_math_unit_pkg::*; #(
  parameter int unsigned W    = 32,
  parameter int unsigned ID_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      in_op_i,
  input  logic [W-1:0]    in_a_i,
  input  logic [W-1:0]    in_b_i,
  input  logic [ID_W-1:0] in_id_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [W-1:0]    out_q_o,
  output logic [W-1:0]    out_r_o,
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
  output logic            out_err_o,
`endif
  output logic [ID_W-1:0] out_id_o
);

  localparam int unsigned CntW = cnt_width(W);

  smu_state_e      state_q;
  math_op_e        op_q;
  logic [W-1:0]    b_q;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    scan_q;
  logic [W-1:0]    clog_q;

  logic            accept;
  logic            core_done;
  logic [CntW-1:0] core_cnt;
  logic [W-1:0]    core_q;
  logic [W-1:0]    core_r;
  logic            b_zero;
  logic [W-1:0]    res_q_d;
  logic [W-1:0]    res_r_d;
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
  logic            res_err_d;
`endif

  assign in_ready_o = (state_q == SMU_IDLE);
  assign accept     = in_valid_i && in_ready_o;
  assign b_zero     = (b_q == '0);

  seq_div_core #(
    .W    (W),
    .CntW (CntW)
  ) u_div_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (accept),
    .dividend_i (in_a_i),
    .divisor_i  (b_q),
    .done_o     (core_done),
    .cnt_o      (core_cnt),
    .q_o        (core_q),
    .r_o        (core_r)
  );

  always_comb begin
    res_q_d = core_q;
    res_r_d = core_r;
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
    res_err_d = 1'b0;
`endif
    case (op_q)
      MATH_DIV: begin
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
        res_err_d = b_zero;
`endif
      end
      MATH_CEILDIV: begin
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
        res_err_d = b_zero;
`endif
        // Divide by zero keeps the all-ones quotient instead of wrapping to 0.
        if (!b_zero && (core_r != '0)) res_q_d = core_q + W'(1);
      end
      MATH_CLOG2: begin
        res_q_d = clog_q;
        res_r_d = '0;
      end
      MATH_MAX: begin
        res_q_d = scan_q;
        res_r_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SMU_IDLE;
      op_q        <= MATH_DIV;
      b_q         <= '0;
      id_q        <= '0;
      scan_q      <= '0;
      clog_q      <= '0;
      out_valid_o <= 1'b0;
      out_q_o     <= '0;
      out_r_o     <= '0;
      out_id_o    <= '0;
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
      out_err_o   <= 1'b0;
`endif
    end else begin
      case (state_q)
        SMU_IDLE: begin
          if (accept) begin
            op_q    <= math_op_e'(in_op_i);
            b_q     <= in_b_i;
            id_q    <= in_id_i;
            clog_q  <= '0;
            state_q <= SMU_BUSY;
            // MAX resolves its compare here; CLOG2 scans a-1 (a=0 treated like a=1).
            if (math_op_e'(in_op_i) == MATH_MAX) begin
              scan_q <= (in_a_i >= in_b_i) ? in_a_i : in_b_i;
            end else begin
              scan_q <= (in_a_i == '0) ? '0 : in_a_i - W'(1);
            end
          end
        end
        SMU_BUSY: begin
          if (op_q == MATH_CLOG2) begin
            scan_q <= scan_q << 1;
            // clog_q stays 0 until the first set bit, so it doubles as the found flag.
            if ((clog_q == '0) && scan_q[W-1]) clog_q <= W'(core_cnt) + W'(1);
          end
          if (core_done) state_q <= SMU_DONE;
        end
        SMU_DONE: begin
          if (!out_valid_o) begin
            out_valid_o <= 1'b1;
            out_q_o     <= res_q_d;
            out_r_o     <= res_r_d;
            out_id_o    <= id_q;
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
            out_err_o   <= res_err_d;
`endif
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= SMU_IDLE;
          end
        end
        default: state_q <= SMU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_math_unit.sv
// Self-checking bench for seq_math_unit: directed vectors, random ops vs. a reference model,
// back-pressure, mid-operation reset and back-to-back requests.
module tb_seq_math_unit;

  localparam int W    = 32;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_op = '0;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic [ID_W-1:0] in_id = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    out_q;
  logic [W-1:0]    out_r;
  logic [ID_W-1:0] out_id;
  logic            out_err;

  int checks   = 0;
  int failures = 0;

  seq_math_unit #(
    .W    (W),
    .ID_W (ID_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_id_i     (in_id),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_q_o     (out_q),
    .out_r_o     (out_r),
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
    .out_err_o   (out_err),
`endif
    .out_id_o    (out_id)
  );

`ifndef SEQ_MATH_UNIT_DIV0_FLAG_EN
  assign out_err = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "timeout");
  end

  // Reference: results from the arithmetic definitions, not the bit-serial algorithm.
  task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    longint unsigned aa, bb;
    int n;
    aa = 64'(a);
    bb = 64'(b);
    q  = '0;
    r  = '0;
    e  = 1'b0;
    case (op)
      2'd0, 2'd1: begin
        if (b == '0) begin
          q = '1;
          r = a;
          e = 1'b1;
        end else begin
          q = W'(aa / bb);
          r = W'(aa % bb);
          if (op == 2'd1 && r != '0) q = q + 1;
        end
      end
      2'd2: begin
        n = 0;
        while ((64'd1 << n) < aa) n++;
        q = W'(n);
      end
      default: q = (a >= b) ? a : b;
    endcase
  endtask

  // Issue one request, wait for the response, capture it, then complete the handshake.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [ID_W-1:0] id, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic e, output logic [ID_W-1:0] oid,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_id    = id;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    in_id    = ID_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q   = out_q;
    r   = out_r;
    e   = out_err;
    oid = out_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_q !== '0) begin failures++; $display("FAIL reset_out_q got=%h exp=0", out_q); end
    checks++; if (out_r !== '0) begin failures++; $display("FAIL reset_out_r got=%h exp=0", out_r); end
    checks++; if (out_id !== '0) begin failures++; $display("FAIL reset_out_id got=%h exp=0", out_id); end
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[$];
    logic [W-1:0] q, r;
    logic e;
    logic [ID_W-1:0] oid, id;
    int lat;
    vecs.push_back('{2'd0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{2'd1, 32'd100, 32'd8, 32'd13, 32'd4, 1'b0});
    vecs.push_back('{2'd1, 32'd96, 32'd8, 32'd12, 32'd0, 1'b0});
    vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0});
    vecs.push_back('{2'd2, 32'd0, 32'd77, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{2'd2, 32'd1, 32'd3, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{2'd2, 32'd5, 32'd0, 32'd3, 32'd0, 1'b0});
    vecs.push_back('{2'd2, 32'd64, 32'd9, 32'd6, 32'd0, 1'b0});
    vecs.push_back('{2'd2, 32'hFFFFFFFF, 32'd1, 32'd32, 32'd0, 1'b0});
    vecs.push_back('{2'd3, 32'd3, 32'd9, 32'd9, 32'd0, 1'b0});
    vecs.push_back('{2'd3, 32'd9, 32'd3, 32'd9, 32'd0, 1'b0});
    vecs.push_back('{2'd0, 32'd17, 32'd0, 32'hFFFFFFFF, 32'd17, 1'b1});
    vecs.push_back('{2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1});
    foreach (vecs[i]) begin
      id = ID_W'(i + 3);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, id, q, r, e, oid, lat);
      checks++; if (lat !== W + 1) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
      checks++; if (q !== vecs[i].q) begin failures++; $display("FAIL dir%0d_q got=%h exp=%h", i, q, vecs[i].q); end
      checks++; if (r !== vecs[i].r) begin failures++; $display("FAIL dir%0d_r got=%h exp=%h", i, r, vecs[i].r); end
      checks++; if (oid !== id) begin failures++; $display("FAIL dir%0d_id got=%h exp=%h", i, oid, id); end
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
      checks++; if (e !== vecs[i].e) begin failures++; $display("FAIL dir%0d_err got=%b exp=%b", i, e, vecs[i].e); end
`endif
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL dir%0d_return_idle out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [W-1:0] a, b, q, r, eq, er;
    logic e, ee;
    logic [ID_W-1:0] id, oid;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      case ($urandom_range(3))
        0: a = $urandom_range(20);
        1: a = 32'd1 << $urandom_range(31);
        default: a = $urandom;
      endcase
      case ($urandom_range(4))
        0: b = '0;
        1: b = $urandom_range(15);
        2: b = a;
        default: b = $urandom;
      endcase
      id = ID_W'($urandom);
      ref_model(op, a, b, eq, er, ee);
      run_op(op, a, b, id, q, r, e, oid, lat);
      checks++;
      if (lat !== W + 1 || q !== eq || r !== er || oid !== id) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got q=%h r=%h id=%h lat=%0d exp q=%h r=%h id=%h lat=%0d",
                 i, op, a, b, q, r, oid, lat, eq, er, id, W + 1);
      end
`ifdef SEQ_MATH_UNIT_DIV0_FLAG_EN
      checks++; if (e !== ee) begin failures++; $display("FAIL rand%0d_err got=%b exp=%b", i, e, ee); end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, eq, er, cq, cr;
    logic ee;
    logic [ID_W-1:0] cid;
    int guard;
    a = $urandom;
    b = $urandom_range(1000, 1);
    ref_model(2'd0, a, b, eq, er, ee);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = a; in_b = b; in_id = 4'hA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    cq = out_q; cr = out_r; cid = out_id;
    checks++; if (cq !== eq || cr !== er || cid !== 4'hA) begin
      failures++; $display("FAIL bp_result got q=%h r=%h id=%h exp q=%h r=%h id=a", cq, cr, cid, eq, er);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom; in_id = ID_W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== cq || out_r !== cr || out_id !== cid) begin
        failures++;
        $display("FAIL bp_hold%0d valid=%b ready=%b q=%h r=%h id=%h exp 1/0 q=%h r=%h id=%h",
                 i, out_valid, in_ready, out_q, out_r, out_id, cq, cr, cid);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release valid=%b ready=%b exp 0/1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_no_stale_accept ready=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_busy();
    logic [W-1:0] a, b, q, r, eq, er;
    logic e, ee;
    logic [ID_W-1:0] oid;
    int lat, seen;
    in_valid = 1'b1; in_op = 2'd1; in_a = $urandom; in_b = $urandom_range(50, 1); in_id = 4'h5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_q !== '0 || out_id !== '0) begin
      failures++; $display("FAIL rst_mid_busy valid=%b ready=%b q=%h id=%h exp 0/1/0/0",
                           out_valid, in_ready, out_q, out_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rst_discard bad_cycles got=%0d exp=0", seen); end
    a = $urandom;
    b = $urandom_range(99, 1);
    ref_model(2'd0, a, b, eq, er, ee);
    run_op(2'd0, a, b, 4'h9, q, r, e, oid, lat);
    checks++; if (q !== eq || r !== er || oid !== 4'h9 || lat !== W + 1) begin
      failures++; $display("FAIL rst_next_op got q=%h r=%h id=%h lat=%0d exp q=%h r=%h id=9 lat=%0d",
                           q, r, oid, lat, eq, er, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq, er;
    logic ee;
    int guard;
    ref_model(2'd3, 32'd40, 32'd41, eq, er, ee);
    in_valid = 1'b1; in_op = 2'd3; in_a = 32'd40; in_b = 32'd41; in_id = 4'h1;
    @(posedge clk); #1;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    // in_valid stays high across the response handshake.
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_done got=%b exp=0", in_ready); end
    in_op = 2'd2; in_a = 32'd1000; in_b = 32'd0; in_id = 4'h2;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_no_accept_on_handshake ready=%b valid=%b exp 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept ready=%b exp=0", in_ready); end
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (guard !== W + 1 || out_q !== 32'd10 || out_r !== '0 || out_id !== 4'h2) begin
      failures++; $display("FAIL b2b_second_result q=%h r=%h id=%h lat=%0d exp q=a r=0 id=2 lat=%0d",
                           out_q, out_r, out_id, guard, W + 1);
    end
    @(posedge clk); #1;
    checks++; if (eq !== 32'd41) begin failures++; $display("FAIL b2b_model_max got=%h exp=29", eq); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
